// File: rtl/arm_ctrl_pkg.sv
// Shared types and constants for the multicycle ARM control unit:
// FSM states, ALU select codes, DP cmd codes, condition codes, flag bit indices.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_mc_controller_cond.sv
// Condition unit: flag register, condition evaluation, condex_q, enable gating.
// Ports: clk/reset, cond, alu_flags, rd, flag_w, FSM strobes -> gated enables, flags.
module arm_cond_logic
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [3:0] rd,
  input  logic [1:0] flag_w,
  input  logic       latch_condex,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       branch,
  input  logic       next_pc,
  input  logic       no_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       pc_write,
  output logic [3:0] flags
);

  logic cond_ex;
  logic condex_q;
  logic n, z, c, v;
  logic ge, hi;
  logic pcs;

  assign n  = flags[FLAG_N];
  assign z  = flags[FLAG_Z];
  assign c  = flags[FLAG_C];
  assign v  = flags[FLAG_V];
  assign ge = (n == v);
  assign hi = c & ~z;

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = hi;
      COND_LS: cond_ex = ~hi;
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = ~ge;
      COND_GT: cond_ex = ~z & ge;
      COND_LE: cond_ex = ~(~z & ge);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
    endcase
  end

  // flag_w is only nonzero in EXECR/EXECI, so no state check is needed here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags    <= FLAGS_RST;
      condex_q <= 1'b0;
    end else begin
      if (latch_condex)
        condex_q <= cond_ex;
      if (flag_w[1] & condex_q)
        flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] & condex_q)
        flags[1:0] <= alu_flags[1:0];
    end
  end

  assign pcs       = branch | (reg_w & (rd == 4'd15));
  assign reg_write = reg_w & condex_q & ~no_write & ~reset;
  assign mem_write = mem_w & condex_q & ~reset;
  assign pc_write  = (next_pc | (pcs & condex_q)) & ~reset;

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: Moore FSM sequencing the datapath plus ALU decoder.
// Ports: instruction fields + ALUFlags in; enables, mux selects, ALUControl, Flags out.
// Optional: define ARM_MC_CMP_EN to decode cmd 1010 with S=1 as CMP.
module arm_mc_controller
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags
);

  state_t state_q, state_d;

  logic       next_pc, ir_w, reg_w, mem_w, branch, alu_op;
  logic       latch_condex;
  logic [3:0] cmd;
  logic       s_bit;
  logic [1:0] dp_ctrl;
  logic       dp_valid, dp_arith, dp_cmp;
  logic       no_write;
  logic [1:0] flag_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    next_pc      = 1'b0;
    ir_w         = 1'b0;
    reg_w        = 1'b0;
    mem_w        = 1'b0;
    branch       = 1'b0;
    alu_op       = 1'b0;
    latch_condex = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    unique case (state_q)
      FETCH: begin
        ir_w      = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = DECODE;
      end
      DECODE: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        latch_condex = 1'b1;
        case (Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc  = 1'b1;
        mem_w   = 1'b1;
        state_d = FETCH;
      end
      EXECR: begin
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_w   = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign cmd   = Funct[4:1];
  assign s_bit = Funct[0];

  always_comb begin
    dp_ctrl  = ALU_ADD;
    dp_valid = 1'b1;
    dp_arith = 1'b0;
    dp_cmp   = 1'b0;
    case (cmd)
      CMD_ADD: begin dp_ctrl = ALU_ADD; dp_arith = 1'b1; end
      CMD_SUB: begin dp_ctrl = ALU_SUB; dp_arith = 1'b1; end
      CMD_AND: dp_ctrl = ALU_AND;
      CMD_ORR: dp_ctrl = ALU_ORR;
`ifdef ARM_MC_CMP_EN
      CMD_CMP: begin
        if (s_bit) begin
          dp_ctrl  = ALU_SUB;
          dp_arith = 1'b1;
          dp_cmp   = 1'b1;
        end else begin
          dp_valid = 1'b0;
        end
      end
`endif
      default: dp_valid = 1'b0;
    endcase
  end

  // NoWrite is evaluated from the held Funct so it still blocks RegWrite in ALUWB.
  assign no_write   = (Op == 2'b00) & (~dp_valid | dp_cmp);
  assign ALUControl = alu_op ? dp_ctrl : ALU_ADD;
  assign flag_w[1]  = alu_op & s_bit & dp_valid;
  assign flag_w[0]  = alu_op & s_bit & dp_valid & dp_arith;

  assign IRWrite = ir_w & ~reset;
  assign ImmSrc  = Op;
  assign RegSrc  = {Op == 2'b01, Op == 2'b10};

  arm_cond_logic #(
    .FLAGS_RST(FLAGS_RST)
  ) u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond        (Cond),
    .alu_flags   (ALUFlags),
    .rd          (Rd),
    .flag_w      (flag_w),
    .latch_condex(latch_condex),
    .reg_w       (reg_w),
    .mem_w       (mem_w),
    .branch      (branch),
    .next_pc     (next_pc),
    .no_write    (no_write),
    .reg_write   (RegWrite),
    .mem_write   (MemWrite),
    .pc_write    (PCWrite),
    .flags       (Flags)
  );

endmodule
